// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: opcode/funct constants, ALU op encodings and decode-result struct
package cpu_defs_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_MOVZ = 6'h0A, F_MOVN = 6'h0B;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [7:0] ALU_NOP = 8'd0, ALU_AND = 8'd1, ALU_OR = 8'd2, ALU_XOR = 8'd3;
  localparam logic [7:0] ALU_NOR = 8'd4, ALU_SLL = 8'd5, ALU_SRL = 8'd6, ALU_SRA = 8'd7;
  localparam logic [7:0] ALU_ADD = 8'd8, ALU_MOVZ = 8'd9, ALU_MOVN = 8'd10, ALU_MFHI = 8'd11;
  localparam logic [7:0] ALU_MFLO = 8'd12, ALU_MTHI = 8'd13, ALU_MTLO = 8'd14;
  // re1/re2 mark rs/rt as real sources; src1 falls back to imm1, src2 takes imm2 when src2_imm
  typedef struct packed {
    logic [7:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        re1;
    logic        re2;
    logic        src2_imm;
    logic [31:0] imm1;
    logic [31:0] imm2;
    logic [4:0]  waddr;
    logic        we;
    logic        mem_re;
    logic        mem_we;
    logic        illegal;
  } dec_t;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/id_decoder.sv
// id_decoder: combinational MIPS-subset decode into op, sources, immediates and write/mem flags
module id_decoder
  import cpu_defs_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);
  logic [5:0] opc, fn;
  logic [4:0] rt, rd, sa;
  logic [15:0] imm;
  assign opc = inst_i[31:26];
  assign rt  = inst_i[20:16];
  assign rd  = inst_i[15:11];
  assign sa  = inst_i[10:6];
  assign fn  = inst_i[5:0];
  assign imm = inst_i[15:0];
  // field decode; a zero destination never writes
  always_comb begin
    dec_o = '0;
    dec_o.rs = inst_i[25:21];
    dec_o.rt = rt;
    case (opc)
      OP_SPECIAL: begin
        dec_o.re1 = 1'b1;
        dec_o.re2 = 1'b1;
        dec_o.waddr = rd;
        dec_o.we = 1'b1;
        case (fn)
          F_AND:  dec_o.op = ALU_AND;
          F_OR:   dec_o.op = ALU_OR;
          F_XOR:  dec_o.op = ALU_XOR;
          F_NOR:  dec_o.op = ALU_NOR;
          F_SLL:  begin dec_o.op = ALU_SLL; dec_o.re1 = 1'b0; dec_o.imm1 = {27'd0, sa}; end
          F_SRL:  begin dec_o.op = ALU_SRL; dec_o.re1 = 1'b0; dec_o.imm1 = {27'd0, sa}; end
          F_SRA:  begin dec_o.op = ALU_SRA; dec_o.re1 = 1'b0; dec_o.imm1 = {27'd0, sa}; end
          F_SLLV: dec_o.op = ALU_SLL;
          F_SRLV: dec_o.op = ALU_SRL;
          F_SRAV: dec_o.op = ALU_SRA;
          F_MOVZ: dec_o.op = ALU_MOVZ;
          F_MOVN: dec_o.op = ALU_MOVN;
          F_MFHI: begin dec_o.op = ALU_MFHI; dec_o.re1 = 1'b0; dec_o.re2 = 1'b0; end
          F_MFLO: begin dec_o.op = ALU_MFLO; dec_o.re1 = 1'b0; dec_o.re2 = 1'b0; end
          F_MTHI: begin dec_o.op = ALU_MTHI; dec_o.re2 = 1'b0; dec_o.we = 1'b0; dec_o.waddr = 5'd0; end
          F_MTLO: begin dec_o.op = ALU_MTLO; dec_o.re2 = 1'b0; dec_o.we = 1'b0; dec_o.waddr = 5'd0; end
          default: begin
            dec_o.re1 = 1'b0;
            dec_o.re2 = 1'b0;
            dec_o.we = 1'b0;
            dec_o.waddr = 5'd0;
            dec_o.illegal = 1'b1;
          end
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_o.op = opc == OP_ANDI ? ALU_AND : opc == OP_ORI ? ALU_OR : ALU_XOR;
        dec_o.re1 = 1'b1;
        dec_o.src2_imm = 1'b1;
        dec_o.imm2 = {16'd0, imm};
        dec_o.waddr = rt;
        dec_o.we = 1'b1;
      end
      OP_LUI: begin
        dec_o.op = ALU_OR;
        dec_o.src2_imm = 1'b1;
        dec_o.imm2 = {imm, 16'd0};
        dec_o.waddr = rt;
        dec_o.we = 1'b1;
      end
      OP_LW: begin
        dec_o.op = ALU_ADD;
        dec_o.re1 = 1'b1;
        dec_o.src2_imm = 1'b1;
        dec_o.imm2 = sext16(imm);
        dec_o.mem_re = 1'b1;
        dec_o.waddr = rt;
        dec_o.we = 1'b1;
      end
      OP_SW: begin
        dec_o.op = ALU_ADD;
        dec_o.re1 = 1'b1;
        dec_o.re2 = 1'b1;
        dec_o.src2_imm = 1'b1;
        dec_o.imm2 = sext16(imm);
        dec_o.mem_we = 1'b1;
      end
      default: dec_o.illegal = 1'b1;
    endcase
    dec_o.we = dec_o.we && dec_o.waddr != 5'd0;
  end
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with ID/EX register, handshakes, bypass and hazard stall (macro ID_BYPASS_EN enables forwarding)
module id_stage_pipe
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_inst,
  output logic [REG_AW-1:0]  rf_raddr1,
  output logic [REG_AW-1:0]  rf_raddr2,
  input  logic [DATA_W-1:0]  rf_rdata1,
  input  logic [DATA_W-1:0]  rf_rdata2,
  input  logic               ex_we,
  input  logic               ex_mem_re,
  input  logic [REG_AW-1:0]  ex_waddr,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic               mem_we,
  input  logic [REG_AW-1:0]  mem_waddr,
  input  logic [DATA_W-1:0]  mem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [ALUOP_W-1:0] out_alu_op,
  output logic [DATA_W-1:0]  out_src1,
  output logic [DATA_W-1:0]  out_src2,
  output logic [DATA_W-1:0]  out_store_data,
  output logic               out_we,
  output logic [REG_AW-1:0]  out_waddr,
  output logic               out_mem_re,
  output logic               out_mem_we,
  output logic               out_illegal
);
  typedef struct packed {
    logic               valid;
    logic [31:0]        pc;
    logic [ALUOP_W-1:0] op;
    logic [DATA_W-1:0]  src1;
    logic [DATA_W-1:0]  src2;
    logic [DATA_W-1:0]  sd;
    logic               we;
    logic [REG_AW-1:0]  waddr;
    logic               mem_re;
    logic               mem_we;
    logic               illegal;
  } idex_t;
  dec_t dec;
  idex_t idex_q, idex_d, idex_new;
  logic [REG_AW-1:0] rs, rt;
  logic [DATA_W-1:0] v1, v2;
  logic stall, accept;
  id_decoder u_dec (.inst_i(in_inst), .dec_o(dec));
  assign rs = REG_AW'(dec.rs);
  assign rt = REG_AW'(dec.rt);
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;
`ifdef ID_BYPASS_EN
  assign v1 = (ex_we && ex_waddr == rs && rs != '0) ? ex_result :
              (mem_we && mem_waddr == rs && rs != '0) ? mem_data : rf_rdata1;
  assign v2 = (ex_we && ex_waddr == rt && rt != '0) ? ex_result :
              (mem_we && mem_waddr == rt && rt != '0) ? mem_data : rf_rdata2;
  assign stall = ex_mem_re && ex_we && ex_waddr != '0 &&
                 ((dec.re1 && ex_waddr == rs) || (dec.re2 && ex_waddr == rt));
`else
  logic unused_fwd;
  assign unused_fwd = &{1'b0, ex_mem_re, ex_result, mem_data};
  assign v1 = rf_rdata1;
  assign v2 = rf_rdata2;
  assign stall = (dec.re1 && rs != '0 && ((ex_we && ex_waddr == rs) || (mem_we && mem_waddr == rs))) ||
                 (dec.re2 && rt != '0 && ((ex_we && ex_waddr == rt) || (mem_we && mem_waddr == rt)));
`endif
  assign in_ready = !rst && !flush && !stall && (!idex_q.valid || out_ready);
  assign accept = in_valid && in_ready;
  // assemble the ID/EX entry from decode and the (possibly forwarded) operands
  always_comb begin
    idex_new = '0;
    idex_new.valid = 1'b1;
    idex_new.pc = in_pc;
    idex_new.op = ALUOP_W'(dec.op);
    idex_new.src1 = dec.re1 ? v1 : DATA_W'(dec.imm1);
    idex_new.src2 = dec.src2_imm ? DATA_W'(dec.imm2) : dec.re2 ? v2 : '0;
    idex_new.sd = dec.mem_we ? v2 : '0;
    idex_new.we = dec.we;
    idex_new.waddr = REG_AW'(dec.waddr);
    idex_new.mem_re = dec.mem_re;
    idex_new.mem_we = dec.mem_we;
    idex_new.illegal = dec.illegal;
  end
  // next ID/EX state: reset, then flush, then accept, then drain to a bubble
  always_comb begin
    idex_d = idex_q;
    if (rst) idex_d = '0;
    else if (flush) idex_d.valid = 1'b0;
    else if (accept) idex_d = idex_new;
    else if (out_ready) idex_d.valid = 1'b0;
  end
  // ID/EX pipeline register
  always_ff @(posedge clk) idex_q <= idex_d;
  assign out_valid = idex_q.valid;
  assign out_pc = idex_q.pc;
  assign out_alu_op = idex_q.op;
  assign out_src1 = idex_q.src1;
  assign out_src2 = idex_q.src2;
  assign out_store_data = idex_q.sd;
  assign out_we = idex_q.we;
  assign out_waddr = idex_q.waddr;
  assign out_mem_re = idex_q.mem_re;
  assign out_mem_we = idex_q.mem_we;
  assign out_illegal = idex_q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: randomized scoreboard bench for id_stage_pipe against a spec-level decode model
module tb_id_stage_pipe;
  import cpu_defs_pkg::*;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] sd;
    logic        we;
    logic [4:0]  wa;
    logic        mre;
    logic        mwe;
    logic        ill;
  } exp_t;
  logic clk = 0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, rf_rdata1, rf_rdata2, ex_result, mem_data;
  logic [4:0] rf_raddr1, rf_raddr2, ex_waddr, mem_waddr, out_waddr;
  logic ex_we, ex_mem_re, mem_we, out_we, out_mem_re, out_mem_we, out_illegal;
  logic [31:0] out_pc, out_src1, out_src2, out_store_data;
  logic [7:0] out_alu_op;
  logic [31:0] rf [32];
  exp_t q[$];
  exp_t outs, snap;
  logic mvalid = 0, hold = 0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  id_stage_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .ex_we(ex_we), .ex_mem_re(ex_mem_re),
    .ex_waddr(ex_waddr), .ex_result(ex_result), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_op(out_alu_op), .out_src1(out_src1), .out_src2(out_src2),
    .out_store_data(out_store_data), .out_we(out_we), .out_waddr(out_waddr),
    .out_mem_re(out_mem_re), .out_mem_we(out_mem_we), .out_illegal(out_illegal)
  );
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  assign outs = {out_pc, out_alu_op, out_src1, out_src2, out_store_data, out_we, out_waddr,
                 out_mem_re, out_mem_we, out_illegal};
  task automatic chk(input string nm, input logic [144:0] act, input logic [144:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] val(input logic [4:0] r);
`ifdef ID_BYPASS_EN
    if (r != 0 && ex_we && ex_waddr == r) return ex_result;
    if (r != 0 && mem_we && mem_waddr == r) return mem_data;
`endif
    return rf[r];
  endfunction
  function automatic logic hit(input logic [4:0] r);
`ifdef ID_BYPASS_EN
    return r != 0 && ex_mem_re && ex_we && ex_waddr == r;
`else
    return r != 0 && ((ex_we && ex_waddr == r) || (mem_we && mem_waddr == r));
`endif
  endfunction
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                 output logic u1, output logic u2);
    exp_t e;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11]; imm = inst[15:0];
    e = '0; e.pc = pc; e.op = ALU_NOP; u1 = 0; u2 = 0;
    case (inst[31:26])
      6'h00: case (inst[5:0])
        6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07, 6'h0A, 6'h0B: begin
          case (inst[5:0])
            6'h24: e.op = ALU_AND;
            6'h25: e.op = ALU_OR;
            6'h26: e.op = ALU_XOR;
            6'h27: e.op = ALU_NOR;
            6'h04: e.op = ALU_SLL;
            6'h06: e.op = ALU_SRL;
            6'h07: e.op = ALU_SRA;
            6'h0A: e.op = ALU_MOVZ;
            default: e.op = ALU_MOVN;
          endcase
          u1 = 1; u2 = 1; e.s1 = val(rs); e.s2 = val(rt); e.wa = rd; e.we = 1;
        end
        6'h00, 6'h02, 6'h03: begin
          e.op = inst[1] ? (inst[0] ? ALU_SRA : ALU_SRL) : ALU_SLL;
          u2 = 1; e.s1 = {27'd0, inst[10:6]}; e.s2 = val(rt); e.wa = rd; e.we = 1;
        end
        6'h10, 6'h12: begin e.op = inst[1] ? ALU_MFLO : ALU_MFHI; e.wa = rd; e.we = 1; end
        6'h11, 6'h13: begin e.op = inst[1] ? ALU_MTLO : ALU_MTHI; u1 = 1; e.s1 = val(rs); end
        default: e.ill = 1;
      endcase
      6'h0C, 6'h0D, 6'h0E: begin
        e.op = inst[27:26] == 2'b00 ? ALU_AND : inst[27:26] == 2'b01 ? ALU_OR : ALU_XOR;
        u1 = 1; e.s1 = val(rs); e.s2 = {16'd0, imm}; e.wa = rt; e.we = 1;
      end
      6'h0F: begin e.op = ALU_OR; e.s2 = {imm, 16'd0}; e.wa = rt; e.we = 1; end
      6'h23: begin
        e.op = ALU_ADD; u1 = 1; e.s1 = val(rs); e.s2 = 32'($signed(imm));
        e.mre = 1; e.wa = rt; e.we = 1;
      end
      6'h2B: begin
        e.op = ALU_ADD; u1 = 1; u2 = 1; e.s1 = val(rs); e.s2 = 32'($signed(imm));
        e.mwe = 1; e.sd = val(rt);
      end
      default: e.ill = 1;
    endcase
    if (e.wa == 0) e.we = 0;
    return e;
  endfunction
  function automatic logic [31:0] rand_inst();
    logic [5:0] fn_t [16];
    logic [5:0] op_t [6];
    logic [31:0] i;
    int k;
    fn_t = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h04,
             6'h06, 6'h07, 6'h0A, 6'h0B, 6'h10, 6'h11, 6'h12, 6'h13};
    op_t = '{6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    k = int'($urandom_range(0, 23));
    i = $urandom;
    i[25:21] = 5'($urandom_range(0, 7));
    i[20:16] = 5'($urandom_range(0, 7));
    i[15:11] = 5'($urandom_range(0, 7));
    if (k < 16) begin i[31:26] = 6'h00; i[5:0] = fn_t[k]; end
    else if (k < 22) i[31:26] = op_t[k-16];
    else if (k == 22) begin i[31:26] = 6'h00; i[5:0] = 6'h01; end
    else i[31:26] = 6'h3F;
    return i;
  endfunction
  task automatic step();
    exp_t e;
    logic u1, u2, rdy;
    #1;
    e = model(in_inst, in_pc, u1, u2);
    rdy = !rst && !flush && !((u1 && hit(in_inst[25:21])) || (u2 && hit(in_inst[20:16]))) &&
          (!mvalid || out_ready);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, mvalid);
    if (rst) begin
      q.delete();
      mvalid = 0;
    end else begin
      if (flush && mvalid && !out_ready) void'(q.pop_front());
      if (in_valid && rdy) q.push_back(e);
      mvalid = flush ? 1'b0 : (in_valid && rdy) ? 1'b1 : (mvalid && out_ready) ? 1'b0 : mvalid;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid = 0; flush = 0; out_ready = 1; ex_we = 0; ex_mem_re = 0; ex_waddr = 0;
    ex_result = 0; mem_we = 0; mem_waddr = 0; mem_data = 0;
  endtask
  // monitor: every EX-side transfer is checked against the scoreboard; held outputs must not move
  always @(negedge clk) begin
    if (hold && out_valid) chk("hold_stable", outs, snap);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_out: got pc %h with nothing expected", out_pc);
      end else chk("out_fields", outs, q.pop_front());
    end
    hold = out_valid && !out_ready && !flush && !rst;
    snap = outs;
  end
  initial begin
    rst = 1; in_pc = 0; in_inst = 0;
    idle();
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs, '0);
    chk("reset_valid", out_valid, 0);
    chk("reset_ready", in_ready, 0);
    rst = 0;
    in_valid = 1; in_inst = 32'h34011234; in_pc = 32'h100;
    step();
    in_valid = 0;
    chk("ori_op", out_alu_op, ALU_OR);
    chk("ori_src1", out_src1, 0);
    chk("ori_src2", out_src2, 32'h1234);
    chk("ori_waddr", out_waddr, 1);
    chk("ori_we", out_we, 1);
    step();
    in_valid = 1; in_inst = 32'h00221825; in_pc = 32'h104;
    ex_we = 1; ex_waddr = 1; ex_result = 32'hAAAA0000; mem_we = 1; mem_waddr = 2; mem_data = 32'h5;
    step();
    idle(); in_valid = 1; step();
    in_valid = 0; step();
    in_valid = 1; ex_we = 1; ex_mem_re = 1; ex_waddr = 2; in_pc = 32'h108;
    step();
    idle(); in_valid = 1; step();
    in_valid = 0; step();
    in_valid = 1; in_inst = 32'h3402BEEF; in_pc = 32'h10C; out_ready = 0;
    step();
    in_inst = 32'h34030007; in_pc = 32'h110;
    repeat (3) step();
    out_ready = 1; step();
    in_valid = 0; step();
    in_valid = 1; out_ready = 0; in_inst = 32'h34040001; in_pc = 32'h114;
    step();
    flush = 1; in_inst = 32'h34050002; in_pc = 32'h118;
    step();
    flush = 0; in_valid = 0; step();
    in_valid = 1; out_ready = 0; in_pc = 32'h11C;
    step();
    in_valid = 0; rst = 1;
    step();
    rst = 0;
    chk("midrst_outs", outs, '0);
    idle();
    in_valid = 1; in_inst = 32'h34260007; in_pc = 32'h120; mem_we = 1; mem_waddr = 1; mem_data = 32'h77;
    repeat (2) step();
    mem_we = 0; step();
    in_valid = 0; step();
    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_inst = rand_inst();
      in_pc = $urandom;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 29) == 0;
      ex_we = $urandom_range(0, 2) == 0;
      ex_mem_re = $urandom_range(0, 1) == 1;
      ex_waddr = 5'($urandom_range(0, 7));
      ex_result = $urandom;
      mem_we = $urandom_range(0, 2) == 0;
      mem_waddr = 5'($urandom_range(0, 7));
      mem_data = $urandom;
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(1, 31)] = $urandom;
      step();
    end
    idle();
    repeat (5) step();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
